multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit_pkg.sv | 126 ++++++++++++
 rtl/multicycle_control_unit_cond_logic.sv | 36 +++
 rtl/multicycle_control_unit.sv | 109 ++++++++++
 tb/tb_multicycle_control_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Holds the state enum, opcode/cond/cmd codes, the control word and its per-state decode.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] alucontrol;
        logic       regwrite;
    } ctrl_t;

    // {valid_cmd, alucontrol}; unsupported commands fall back to ADD with valid=0
    function automatic logic [2:0] dp_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: dp_decode = {1'b1, ALU_ADD};
            CMD_SUB: dp_decode = {1'b1, ALU_SUB};
            CMD_AND: dp_decode = {1'b1, ALU_AND};
            CMD_ORR: dp_decode = {1'b1, ALU_ORR};
            default: dp_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic cex, input logic valid,
                                       input logic [1:0] alu, input logic rd15);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.pcwrite   = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            MEMADR: c.alusrcb = SRCB_IMM;
            MEMRD:  c.adrsrc  = 1'b1;
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = cex & ~rd15;
                c.pcwrite   = cex & rd15;
            end
            MEMWR: begin
                c.adrsrc   = 1'b1;
                c.memwrite = cex;
            end
            EXECR: c.alucontrol = alu;
            EXECI: begin
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = alu;
            end
            ALUWB: begin
                c.regwrite = cex & valid & ~rd15;
                c.pcwrite  = cex & valid & rd15;
            end
            BRANCH: begin
                c.alusrcb   = SRCB_IMM;
                c.resultsrc = RES_ALURESULT;
                c.pcwrite   = cex;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_logic.sv
// Combinational ARM condition-code check of cond against the NZCV flag register.
// Zero latency; no handshake.
module cond_logic
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle ARM-subset datapath; owns NZCV and condition gating.
// Control word is registered per state; B=3, DP=4, STR=4, LDR=5 cycles per instruction.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       Instr,
    input  logic [FLAG_W-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ALUControl,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic              RegWrite
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd15;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd15      = (Instr[3:0] == 4'b1111);
    assign unused_rn = ^Instr[7:4];

    state_t            state, state_nxt;
    logic [FLAG_W-1:0] flags_q;
    logic              cond_ex, cond_ex_q, cex_nxt;
    ctrl_t             ctrl_q, ctrl_nxt;
    logic [2:0]        dp;
    logic              valid_cmd;
    logic [1:0]        alu_dec;

    assign dp        = dp_decode(funct[4:1]);
    assign valid_cmd = dp[2];
    assign alu_dec   = dp[1:0];

    cond_logic u_cond (
        .cond    (cond),
        .flags   (flags_q[3:0]),
        .cond_ex (cond_ex)
    );

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  state_nxt = MEMADR;
                    OP_DP:   state_nxt = funct[5] ? EXECI : EXECR;
                    OP_BR:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR:       state_nxt = funct[0] ? MEMRD : MEMWR;
            MEMRD:        state_nxt = MEMWB;
            EXECR, EXECI: state_nxt = ALUWB;
            default:      state_nxt = FETCH;
        endcase
    end

    // The registered control word for the next state must see the cond_ex_q it will run with
    assign cex_nxt  = (state == DECODE) ? cond_ex : cond_ex_q;
    assign ctrl_nxt = ctrl_for(state_nxt, cex_nxt, valid_cmd, alu_dec, rd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
            ctrl_q    <= ctrl_for(FETCH, 1'b0, 1'b0, ALU_ADD, 1'b0);
        end else begin
            state     <= state_nxt;
            cond_ex_q <= cex_nxt;
            ctrl_q    <= ctrl_nxt;
            if ((state == EXECR || state == EXECI) && cond_ex_q && valid_cmd && funct[0]) begin
                flags_q[3:2] <= ALUFlags[3:2];
                // logical ops carry no meaningful C/V
                if (alu_dec == ALU_ADD || alu_dec == ALU_SUB)
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign PCWrite    = ctrl_q.pcwrite  & ~reset;
    assign IRWrite    = ctrl_q.irwrite  & ~reset;
    assign MemWrite   = ctrl_q.memwrite & ~reset;
    assign RegWrite   = ctrl_q.regwrite & ~reset;
    assign AdrSrc     = ctrl_q.adrsrc;
    assign ResultSrc  = ctrl_q.resultsrc;
    assign ALUSrcA    = ctrl_q.alusrca;
    assign ALUSrcB    = ctrl_q.alusrcb;
    assign ALUControl = ctrl_q.alucontrol;
    assign ImmSrc     = op;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed and random instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    int   nerr = 0;
    int   nchk = 0;
    logic [3:0] mflags = 4'b0000;

    multicycle_control_unit #(.FLAG_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    // ARM rule: cond[3:1] picks a base test, cond[0] inverts it (so 1111 is never-true)
    function automatic logic mcond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? ~r : r;
    endfunction

    function automatic logic [15:0] mk(input logic [19:0] ins, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] res,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] alu, input logic rw);
        logic [1:0] op;
        op = ins[15:14];
        return {pcw, adr, mw, irw, res, srca, srcb, alu, rw, op, op == 2'b01, op == 2'b10};
    endfunction

    function automatic logic [15:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegWrite, ImmSrc, RegSrc};
    endfunction

    task automatic chk(input string tag, input logic [19:0] ins, input int cyc,
                       input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s instr=%h cyc=%0d got=%h exp=%h", tag, ins, cyc, got, exp);
        end
    endtask

    // Runs one instruction starting in its FETCH cycle; ALUFlags held at af throughout
    task automatic run_instr(input string tag, input logic [19:0] ins, input logic [3:0] af);
        logic [15:0] q[$];
        logic [1:0]  op, alu;
        logic        cex, rd15, valid;
        logic [3:0]  cmd;
        op    = ins[15:14];
        cmd   = ins[12:9];
        rd15  = (ins[3:0] == 4'hF);
        cex   = mcond(ins[19:16], mflags);
        valid = 1'b1;
        alu   = 2'b00;
        if (cmd == 4'b0100)      alu = 2'b00;
        else if (cmd == 4'b0010) alu = 2'b01;
        else if (cmd == 4'b0000) alu = 2'b10;
        else if (cmd == 4'b1100) alu = 2'b11;
        else valid = 1'b0;

        q.push_back(mk(ins, 1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0));
        q.push_back(mk(ins, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0));
        case (op)
            2'b01: begin
                q.push_back(mk(ins, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0));
                if (ins[8]) begin
                    q.push_back(mk(ins, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
                    q.push_back(mk(ins, cex & rd15, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, cex & ~rd15));
                end else begin
                    q.push_back(mk(ins, 0, 1, cex, 0, 2'b00, 0, 2'b00, 2'b00, 0));
                end
            end
            2'b00: begin
                q.push_back(mk(ins, 0, 0, 0, 0, 2'b00, 0, ins[13] ? 2'b01 : 2'b00, alu, 0));
                q.push_back(mk(ins, cex & valid & rd15, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00,
                               cex & valid & ~rd15));
            end
            2'b10: q.push_back(mk(ins, cex, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0));
            default: ;
        endcase

        Instr    = ins;
        ALUFlags = af;
        for (int k = 0; k < q.size(); k++) begin
            #1;
            chk(tag, ins, k, observed(), q[k]);
            @(posedge clk);
            @(negedge clk);
        end

        if (op == 2'b00 && cex && valid && ins[8]) begin
            mflags[3:2] = af[3:2];
            if (alu == 2'b00 || alu == 2'b01) mflags[1:0] = af[1:0];
        end
    endtask

    initial begin
        logic [19:0] ins;
        logic [3:0]  cmd;
        reset    = 1'b1;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            nchk++;
            assert ({PCWrite, IRWrite, RegWrite, MemWrite} === 4'b0000) else begin
                nerr++;
                $error("FAIL reset_writes got=%b exp=0000", {PCWrite, IRWrite, RegWrite, MemWrite});
            end
        end
        @(negedge clk);
        reset = 1'b0;

        run_instr("add_imm", 20'hE2821, 4'b0000);
        run_instr("subs",    20'hE0500, 4'b0100);
        run_instr("addeq",   20'h02811, 4'b0000);
        run_instr("addne",   20'h12811, 4'b0000);
        run_instr("ldr",     20'hE5921, 4'b0000);
        run_instr("str",     20'hE5821, 4'b0000);
        run_instr("b_al",    20'hEA000, 4'b0000);
        run_instr("subs_z0", 20'hE0500, 4'b0000);
        run_instr("b_eq_z0", 20'h0A000, 4'b0000);
        run_instr("add_pc",  20'hE281F, 4'b0000);
        run_instr("ands",    20'hE0100, 4'b1011);
        run_instr("eor",     20'hE2211, 4'b1111);
        run_instr("cond_nv", 20'hF2811, 4'b0000);
        run_instr("op11",    20'hEC000, 4'b0000);

        // Make Z set, then abort a STR in MEMWR with reset
        run_instr("subs_z1", 20'hE0500, 4'b0100);
        Instr = 20'hE5821;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        nchk++;
        assert ({PCWrite, IRWrite, RegWrite, MemWrite} === 4'b0000) else begin
            nerr++;
            $error("FAIL reset_memwr got=%b exp=0000", {PCWrite, IRWrite, RegWrite, MemWrite});
        end
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mflags = 4'b0000;
        run_instr("post_rst_addeq", 20'h02811, 4'b0000);
        run_instr("post_rst_addne", 20'h12811, 4'b0000);

        for (int i = 0; i < 200; i++) begin
            ins[19:16] = 4'($urandom_range(0, 15));
            ins[15:14] = 2'($urandom_range(0, 3));
            ins[13:8]  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: cmd = 4'b0100;
                    1: cmd = 4'b0010;
                    2: cmd = 4'b0000;
                    default: cmd = 4'b1100;
                endcase
                ins[12:9] = cmd;
            end
            ins[7:4] = 4'($urandom_range(0, 15));
            ins[3:0] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            run_instr("rand", ins, 4'($urandom_range(0, 15)));
        end

        run_instr("final", 20'hE2821, 4'b0000);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
